// File: rtl/seq_divider_6by3_if.sv
// Operand/result handshake bundle for the 6-by-3 sequential divider.
// The master drives operands and takes results; the slave is the divider.
interface seq_divider_6by3_if #(
    parameter int DW = 6,
    parameter int VW = 3
);
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] dividend;
    logic [VW-1:0] divisor;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] quotient;
    logic [VW-1:0] remainder;
    logic          dbz;

    modport master (
        output in_valid, dividend, divisor, out_ready,
        input  in_ready, out_valid, quotient, remainder, dbz
    );

    modport slave (
        input  in_valid, dividend, divisor, out_ready,
        output in_ready, out_valid, quotient, remainder, dbz
    );
endinterface

// File: rtl/seq_divider_6by3.sv
// Iterative restoring divider, one quotient bit per clock.
// Inverse of the 3x3 array multiplier: DW-bit dividend, VW-bit divisor.
module seq_divider_6by3 #(
    parameter int DW = 6,
    parameter int VW = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    seq_divider_6by3_if.slave bus
);
    localparam int CW = $clog2(DW);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t        state;
    state_t        state_nx;
    logic [CW-1:0] cnt;
    logic [DW-1:0] dvd;
    logic [VW-1:0] dvs;
    logic [VW-1:0] pr;
    logic [VW:0]   trial;
    logic [VW:0]   diff;
    logic [VW-1:0] pr_nx;
    logic          ge;
    logic          last;
    logic          zero_div;
    logic [DW-1:0] q_out;
    logic [VW-1:0] r_out;
    logic          dbz_q;

    // pr < dvs always holds, so trial < 2*dvs and diff's top bit is a clean borrow
    assign trial    = {pr, dvd[DW-1]};
    assign diff     = trial - {1'b0, dvs};
    assign ge       = ~diff[VW];
    assign pr_nx    = ge ? diff[VW-1:0] : trial[VW-1:0];
    assign last     = (cnt == CW'(DW - 1));
    assign zero_div = (bus.divisor == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (bus.in_valid) begin
                    state_nx = zero_div ? DONE : CALC;
                end
            end
            CALC: begin
                if (last) begin
                    state_nx = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Quotient bits shift into the dividend register as its MSBs are consumed
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= '0;
            dvd   <= '0;
            dvs   <= '0;
            pr    <= '0;
            q_out <= '0;
            r_out <= '0;
            dbz_q <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        dvd <= bus.dividend;
                        dvs <= bus.divisor;
                        pr  <= '0;
                        cnt <= '0;
                        if (zero_div) begin
                            q_out <= '1;
                            r_out <= '0;
                            dbz_q <= 1'b1;
                        end else begin
                            dbz_q <= 1'b0;
                        end
                    end
                end
                CALC: begin
                    dvd <= {dvd[DW-2:0], ge};
                    pr  <= pr_nx;
                    cnt <= cnt + 1'b1;
                    if (last) begin
                        q_out <= {dvd[DW-2:0], ge};
                        r_out <= pr_nx;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == DONE);
    assign bus.quotient  = q_out;
    assign bus.remainder = r_out;
    assign bus.dbz       = dbz_q;
endmodule
